ahb_bridge_master: RTL and testbench

- AHB-Lite initiator that drives the AHB side of the AHB-to-APB bridge from a simple command/response interface.
- Replaces hand-sequenced testbench stimulus and serves as the SoC-side master for the bridge.
- Two-slot pipeline (address slot, data slot): a new address phase overlaps the previous data phase, giving one transfer per cycle when HREADYOUT stays high.
- Honours bridge wait states (HREADYOUT=0) by holding the address and write data stable.

---
 rtl/ahb_master_pkg.sv | 25 ++
 rtl/ahb_master_timeout_cnt.sv | 37 +++
 rtl/ahb_bridge_master.sv | 113 +++++++++++
 tb/tb_ahb_bridge_master.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_master_pkg.sv
// rtl/ahb_master_pkg.sv - shared types and constants for the AHB bridge master.
// Slot state is encoded as {A full, D full}.
package ahb_master_pkg;

    localparam int AHB_ADDR_W = 7;
    localparam int AHB_DATA_W = 32;

    // HADDR field positions: [6:5] picks the APB slave, [4:0] is PADDR
    localparam int SLV_SEL_MSB = 6;
    localparam int SLV_SEL_LSB = 5;
    localparam int PADDR_MSB   = 4;
    localparam int PADDR_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        DATA      = 2'b01,
        ADDR      = 2'b10,
        ADDR_DATA = 2'b11
    } state_e;

    function automatic state_e slot_state(input logic a_full, input logic d_full);
        return state_e'({a_full, d_full});
    endfunction

endpackage

// File: rtl/ahb_master_timeout_cnt.sv
// rtl/ahb_master_timeout_cnt.sv - data-phase stall counter with expiry compare.
// expire_o fires combinationally on the stalled cycle that reaches TIMEOUT_CYCLES-1.
module ahb_master_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stall_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (stall_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expire_o = stall_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_bridge_master.sv
// rtl/ahb_bridge_master.sv - AHB-Lite initiator with address/data slot pipeline.
// Optional stall timeout enabled by defining MASTER_TIMEOUT_EN.
module ahb_bridge_master
    import ahb_master_pkg::*;
#(
    parameter int ADDR_W         = AHB_ADDR_W,
    parameter int DATA_W         = AHB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              HCLK,
    input  logic              RESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic              HREADY,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADYOUT,
    input  logic [DATA_W-1:0] HRDATA,
    output logic              busy
);

    state_e              state_q;
    logic [ADDR_W-1:0]   haddr_q;
    logic                hwrite_q;
    logic [DATA_W-1:0]   a_wdata_q;
    logic [DATA_W-1:0]   hwdata_q;
    logic                d_write_q;
    logic                rsp_valid_q;
    logic                rsp_write_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic a_full, d_full, a_full_d, d_full_d;
    logic addr_done, data_done, cmd_hs, expire;

    assign a_full = (state_q == ADDR) || (state_q == ADDR_DATA);
    assign d_full = (state_q == DATA) || (state_q == ADDR_DATA);

`ifdef MASTER_TIMEOUT_EN
    ahb_master_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (HCLK),
        .rst_i   (RESET),
        .stall_i (d_full && !HREADYOUT),
        .clear_i (data_done),
        .expire_o(expire)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    // A forced retire looks like a ready data phase to the rest of the pipeline
    assign HREADY    = d_full ? (HREADYOUT || expire) : 1'b1;
    assign addr_done = a_full && HREADY;
    assign data_done = d_full && (HREADYOUT || expire);
    assign cmd_ready = !RESET && (!a_full || HREADY);
    assign cmd_hs    = cmd_valid && cmd_ready;

    assign a_full_d  = cmd_hs || (a_full && !addr_done);
    assign d_full_d  = addr_done || (d_full && !data_done);

    always_ff @(posedge HCLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            a_wdata_q   <= '0;
            hwdata_q    <= '0;
            d_write_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= slot_state(a_full_d, d_full_d);
            if (cmd_hs) begin
                haddr_q   <= cmd_addr;
                hwrite_q  <= cmd_write;
                a_wdata_q <= cmd_wdata;
            end
            if (addr_done) begin
                hwdata_q  <= a_wdata_q;
                d_write_q <= hwrite_q;
            end
            rsp_valid_q <= data_done;
            rsp_write_q <= data_done && d_write_q;
            rsp_rdata_q <= (data_done && !d_write_q && !expire) ? HRDATA : '0;
            rsp_err_q   <= data_done && expire;
        end
    end

    assign HSEL      = a_full;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ahb_bridge_master.sv
// tb/tb_ahb_bridge_master.sv - self-checking bench for ahb_bridge_master.
// Reference model tracks pending transfers as queues; a memory stub supplies HRDATA.
module tb_ahb_bridge_master;

`ifdef MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TMO = 16;

    logic        HCLK = 1'b0;
    logic        RESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic        HSEL, HWRITE, HREADY, HREADYOUT, busy;
    logic [6:0]  HADDR;
    logic [31:0] HWDATA, HRDATA;

    typedef struct {
        logic        w;
        logic [6:0]  a;
        logic [31:0] d;
    } cmd_t;

    logic [31:0] mem [128];
    logic [6:0]  st_addr = '0;
    cmd_t        pend_a[$];
    cmd_t        st_cmd;
    logic        st_valid = 1'b0;
    logic        resp_due = 1'b0;
    logic        re_w, re_e;
    logic [31:0] re_d;
    int          stall_cnt = 0;
    int          total = 0;
    int          bad = 0;

    assign HRDATA = mem[st_addr];

    always #5 HCLK = ~HCLK;

    ahb_bridge_master #(
        .ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .HCLK(HCLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are already set for this cycle; check, then advance the model across the edge
    task automatic cycle();
        logic hsel_e, fx, hr, rdy_e, dd, ad;
        cmd_t c;
        #1;
        hsel_e = (pend_a.size() != 0);
        fx     = TO_EN && st_valid && !HREADYOUT && (stall_cnt == TMO - 1);
        hr     = !st_valid || HREADYOUT || fx;
        rdy_e  = !RESET && (!hsel_e || hr);
        chk("hsel", HSEL, hsel_e);
        chk("hready", HREADY, hr);
        chk("cmd_ready", cmd_ready, rdy_e);
        chk("busy", busy, hsel_e || st_valid);
        chk("rsp_valid", rsp_valid, resp_due);
        if (resp_due) begin
            chk("rsp_write", rsp_write, re_w);
            chk("rsp_rdata", rsp_rdata, re_d);
            chk("rsp_err", rsp_err, re_e);
        end
        if (hsel_e) begin
            chk("haddr", HADDR, pend_a[0].a);
            chk("hwrite", HWRITE, pend_a[0].w);
        end
        if (st_valid && st_cmd.w) chk("hwdata", HWDATA, st_cmd.d);
        c.w = cmd_write;
        c.a = cmd_addr;
        c.d = cmd_wdata;
        @(posedge HCLK);
        #1;
        if (RESET) begin
            pend_a.delete();
            st_valid  = 1'b0;
            resp_due  = 1'b0;
            stall_cnt = 0;
        end else begin
            dd       = st_valid && (HREADYOUT || fx);
            resp_due = dd;
            if (dd) begin
                re_w = st_cmd.w;
                re_d = (st_cmd.w || fx) ? 32'h0 : mem[st_cmd.a];
                re_e = fx;
            end
            if (dd) stall_cnt = 0;
            else if (st_valid && !HREADYOUT) stall_cnt++;
            ad = hsel_e && hr;
            if (ad) begin
                st_cmd   = pend_a.pop_front();
                st_valid = 1'b1;
                st_addr  = st_cmd.a;
            end else if (dd) begin
                st_valid = 1'b0;
            end
            if (cmd_valid && rdy_e) pend_a.push_back(c);
        end
        @(negedge HCLK);
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [6:0] a, input logic [31:0] d);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[7'h41] = 32'h1234_5678;
        RESET     = 1'b1;
        HREADYOUT = 1'b1;
        set_cmd(1'b1, 1'b1, 7'h00, 32'h0);
        @(negedge HCLK);

        // reset held with a pending request
        repeat (3) cycle();
        RESET = 1'b0;
        set_cmd(1'b0, 1'b0, 7'h00, 32'h0);
        cycle();

        // single write
        set_cmd(1'b1, 1'b1, 7'h25, 32'hDEAD_BEEF);
        cycle();
        set_cmd(1'b0, 1'b0, 7'h00, 32'h0);
        repeat (4) cycle();

        // stalled write followed by read of the same address
        set_cmd(1'b1, 1'b1, 7'h41, 32'h0000_00A5);
        cycle();
        set_cmd(1'b1, 1'b0, 7'h41, 32'h0);
        cycle();
        set_cmd(1'b0, 1'b0, 7'h00, 32'h0);
        HREADYOUT = 1'b0;
        repeat (2) cycle();
        HREADYOUT = 1'b1;
        repeat (4) cycle();

        // back-to-back writes
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 1'b1, 7'h20 + 7'(i), 32'hC0DE_0000 + 32'(i));
            cycle();
        end
        set_cmd(1'b0, 1'b0, 7'h00, 32'h0);
        repeat (4) cycle();

        // reset while both slots are occupied
        set_cmd(1'b1, 1'b1, 7'h33, 32'h1111_2222);
        cycle();
        set_cmd(1'b1, 1'b0, 7'h34, 32'h0);
        cycle();
        set_cmd(1'b0, 1'b0, 7'h00, 32'h0);
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        chk("haddr_after_reset", HADDR, 32'h0);
        chk("hwrite_after_reset", HWRITE, 32'h0);
        chk("hwdata_after_reset", HWDATA, 32'h0);
        chk("rsp_err_after_reset", rsp_err, 32'h0);
        repeat (3) cycle();

`ifdef MASTER_TIMEOUT_EN
        // stall long enough to force the write out, then let the read stall briefly
        set_cmd(1'b1, 1'b1, 7'h10, 32'hAAAA_5555);
        cycle();
        set_cmd(1'b1, 1'b0, 7'h11, 32'h0);
        HREADYOUT = 1'b0;
        cycle();
        set_cmd(1'b0, 1'b0, 7'h00, 32'h0);
        repeat (20) cycle();
        HREADYOUT = 1'b1;
        repeat (4) cycle();
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_cmd(($urandom % 10) < 7, $urandom % 2, 7'($urandom), $urandom);
            HREADYOUT = ($urandom % 4) != 0;
            cycle();
        end
        set_cmd(1'b0, 1'b0, 7'h00, 32'h0);
        HREADYOUT = 1'b1;
        repeat (5) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
